// File: rtl/tcdm_cache_offset_ctrl_if.sv
// Bundle of the configuration handshake, the observed core request/response
// handshakes, the gated request valids, the crossbar offset and the flush
// handshake of tcdm_cache_offset_ctrl.
// slave  : the controller side.
// master : the environment side (config registers, cores, crossbar, caches).
interface tcdm_cache_offset_ctrl_if #(
    parameter int unsigned NumCore   = 4,
    parameter int unsigned AddrWidth = 32
);
    localparam int unsigned OffW = $clog2(AddrWidth);

    logic [OffW-1:0]    cfg_offset_i;
    logic               cfg_valid_i;
    logic               cfg_ready_o;
    logic               cfg_err_o;
    logic [NumCore-1:0] core_req_valid_i;
    logic [NumCore-1:0] core_req_ready_i;
    logic [NumCore-1:0] core_req_valid_o;
    logic [NumCore-1:0] core_rsp_valid_i;
    logic [NumCore-1:0] core_rsp_ready_i;
    logic [OffW-1:0]    dynamic_offset_o;
    logic               flush_req_o;
    logic               flush_done_i;
    logic               busy_o;

    modport slave (
        input  cfg_offset_i, cfg_valid_i,
        input  core_req_valid_i, core_req_ready_i,
        input  core_rsp_valid_i, core_rsp_ready_i,
        input  flush_done_i,
        output cfg_ready_o, cfg_err_o, core_req_valid_o,
        output dynamic_offset_o, flush_req_o, busy_o
    );

    modport master (
        output cfg_offset_i, cfg_valid_i,
        output core_req_valid_i, core_req_ready_i,
        output core_rsp_valid_i, core_rsp_ready_i,
        output flush_done_i,
        input  cfg_ready_o, cfg_err_o, core_req_valid_o,
        input  dynamic_offset_o, flush_req_o, busy_o
    );
endinterface

// File: rtl/tcdm_cache_offset_ctrl.sv
// Runtime sequencer for the crossbar bank-select offset.
// Tracks in-flight requests per core, gates new requests while a
// reconfiguration is pending, waits for all outstanding responses,
// optionally has the cache banks flush, then switches the offset.
// Optional feature macro: TCDM_CACHE_OFFSET_FLUSH_EN (adds the FLUSH state
// and the flush_req_o / flush_done_i handshake; otherwise flush_req_o is 0).
module tcdm_cache_offset_ctrl #(
    parameter int unsigned NumCore        = 4,
    parameter int unsigned NumCache       = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned DefaultOffset  = 6
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    tcdm_cache_offset_ctrl_if.slave bus
);
    localparam int unsigned NumMemSelBits = $clog2(NumCache);
    localparam int unsigned OffW          = $clog2(AddrWidth);
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt    = CntW'(MaxOutstanding);
    localparam logic [OffW-1:0] DefOff    = OffW'(DefaultOffset);

`ifdef TCDM_CACHE_OFFSET_FLUSH_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2,
        SWITCH = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd3
    } state_e;
`endif

    state_e                        r_state;
    state_e                        w_state_next;
    logic [OffW-1:0]               r_target;
    logic [OffW-1:0]               w_target_next;
    logic [OffW-1:0]               r_offset;
    logic                          r_err;
    logic [NumCore-1:0][CntW-1:0]  r_cnt;
    logic [NumCore-1:0][CntW-1:0]  w_cnt_next;
    logic [NumCore-1:0]            w_gate;
    logic [NumCore-1:0]            w_req_valid;
    logic [NumCore-1:0]            w_req_hs;
    logic [NumCore-1:0]            w_rsp_hs;
    logic [NumCore-1:0]            w_cnt_zero;
    logic                          w_busy;
    logic                          w_cfg_hs;
    logic                          w_illegal;
    logic                          w_all_zero;
    logic [31:0]                   w_off_sum;

    assign w_busy   = (r_state != IDLE);
    assign w_cfg_hs = bus.cfg_valid_i && (r_state == IDLE);

    // An offset is illegal when the bank-select field would run past the top
    // of the address.
    assign w_off_sum = 32'(bus.cfg_offset_i) + NumMemSelBits;
    assign w_illegal = (w_off_sum > AddrWidth);

    assign w_req_hs   = w_req_valid & bus.core_req_ready_i;
    assign w_rsp_hs   = bus.core_rsp_valid_i & bus.core_rsp_ready_i;
    assign w_all_zero = &w_cnt_zero;

    // Per-core gating and drain-completion flags.
    for (genvar gi = 0; gi < NumCore; gi++) begin : g_core
        // A full counter blocks further requests so it can never overflow.
        assign w_gate[gi]      = w_busy || (r_cnt[gi] == MaxCnt);
        assign w_req_valid[gi] = bus.core_req_valid_i[gi] & ~w_gate[gi];
        // The drain test looks at the post-update count so that the last
        // response and the exit from DRAIN happen in the same cycle.
        assign w_cnt_zero[gi]  = (w_cnt_next[gi] == '0);

        // A response with nothing outstanding is an interconnect bug.
        a_no_rsp_underflow: assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            !(w_rsp_hs[gi] && !w_req_hs[gi] && (r_cnt[gi] == '0))
        );
    end

    assign bus.core_req_valid_o = w_req_valid;

    // Outstanding-request counters: +1 per request, -1 per response, floor 0.
    always_comb begin
        w_cnt_next = r_cnt;
        for (int i = 0; i < NumCore; i++) begin
            if (w_req_hs[i] && !w_rsp_hs[i]) begin
                w_cnt_next[i] = r_cnt[i] + CntW'(1);
            end else if (!w_req_hs[i] && w_rsp_hs[i] && (r_cnt[i] != '0)) begin
                w_cnt_next[i] = r_cnt[i] - CntW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Reconfiguration sequencer: next state and target offset.
    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        case (r_state)
            IDLE: begin
                if (w_cfg_hs && !w_illegal && (bus.cfg_offset_i != r_offset)) begin
                    w_state_next  = DRAIN;
                    w_target_next = bus.cfg_offset_i;
                end
            end
            DRAIN: begin
                if (w_all_zero) begin
`ifdef TCDM_CACHE_OFFSET_FLUSH_EN
                    w_state_next = FLUSH;
`else
                    w_state_next = SWITCH;
`endif
                end
            end
`ifdef TCDM_CACHE_OFFSET_FLUSH_EN
            FLUSH: begin
                if (bus.flush_done_i) begin
                    w_state_next = SWITCH;
                end
            end
`endif
            SWITCH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, target, live offset and error pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_target <= DefOff;
            r_offset <= DefOff;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_target <= w_target_next;
            r_err    <= w_cfg_hs && w_illegal;
            if (r_state == SWITCH) begin
                r_offset <= r_target;
            end
        end
    end

    assign bus.cfg_ready_o      = (r_state == IDLE);
    assign bus.cfg_err_o        = r_err;
    assign bus.busy_o           = w_busy;
    assign bus.dynamic_offset_o = r_offset;

`ifdef TCDM_CACHE_OFFSET_FLUSH_EN
    assign bus.flush_req_o = (r_state == FLUSH);
`else
    // No flush handshake in this build; the input is deliberately ignored.
    logic w_unused_flush_done;
    assign w_unused_flush_done = bus.flush_done_i;
    assign bus.flush_req_o     = 1'b0;
`endif
endmodule

// File: tb/tb_tcdm_cache_offset_ctrl.sv
// Self-checking bench for tcdm_cache_offset_ctrl: directed scenarios plus a
// randomized run, all checked against a behavioural model of the sequencer.
module tb_tcdm_cache_offset_ctrl;
    localparam int NC   = 4;
    localparam int MAXO = 8;
    localparam int DEF  = 6;
    localparam int SELB = 2;
    localparam int AW   = 32;

    logic clk = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    tcdm_cache_offset_ctrl_if #(.NumCore(NC), .AddrWidth(AW)) bus ();

    tcdm_cache_offset_ctrl #(
        .NumCore(NC), .NumCache(4), .AddrWidth(AW),
        .MaxOutstanding(MAXO), .DefaultOffset(DEF)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    // ---------------- behavioural reference model ----------------
    int m_cnt [NC];
    int m_offset;
    int m_target;
    bit m_busy;       // a reconfiguration is in progress
    bit m_drained;    // all responses collected for the pending change
    bit m_switching;  // the offset swaps at the end of this cycle
    bit m_err;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_offset = DEF; m_target = DEF;
        m_busy = 0; m_drained = 0; m_switching = 0; m_err = 0;
    endtask

    function automatic logic [NC-1:0] exp_gate();
        logic [NC-1:0] g;
        for (int i = 0; i < NC; i++) g[i] = m_busy || (m_cnt[i] >= MAXO);
        return g;
    endfunction

    function automatic logic [NC-1:0] exp_req_o();
        return bus.core_req_valid_i & ~exp_gate();
    endfunction

    function automatic bit exp_flush();
`ifdef TCDM_CACHE_OFFSET_FLUSH_EN
        return m_busy && m_drained && !m_switching;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [NC-1:0] g;
        bit all0;
        bit nerr;
        int off;
        g    = exp_gate();
        all0 = 1;
        for (int i = 0; i < NC; i++) begin
            int rq, rs;
            rq = (bus.core_req_valid_i[i] && !g[i] && bus.core_req_ready_i[i]) ? 1 : 0;
            rs = (bus.core_rsp_valid_i[i] && bus.core_rsp_ready_i[i]) ? 1 : 0;
            m_cnt[i] = m_cnt[i] + rq - rs;
            if (m_cnt[i] < 0) m_cnt[i] = 0;
            if (m_cnt[i] != 0) all0 = 0;
        end
        nerr = 0;
        off  = int'(bus.cfg_offset_i);
        if (!m_busy) begin
            if (bus.cfg_valid_i) begin
                if (off + SELB > AW) nerr = 1;
                else if (off != m_offset) begin
                    m_busy = 1; m_target = off; m_drained = 0; m_switching = 0;
                end
            end
        end else if (m_switching) begin
            m_offset = m_target; m_busy = 0; m_switching = 0;
        end else if (!m_drained) begin
            if (all0) begin
                m_drained = 1;
`ifndef TCDM_CACHE_OFFSET_FLUSH_EN
                m_switching = 1;
`endif
            end
        end else if (bus.flush_done_i) begin
            m_switching = 1;
        end
        m_err = nerr;
    endtask

    task automatic set_idle();
        bus.cfg_valid_i      = 1'b0;
        bus.cfg_offset_i     = '0;
        bus.core_req_valid_i = '0;
        bus.core_req_ready_i = '0;
        bus.core_rsp_valid_i = '0;
        bus.core_rsp_ready_i = '0;
        bus.flush_done_i     = 1'b0;
    endtask

    // Called just after the check point of a cycle; returns at the next negedge.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        set_idle();
        bus.core_req_valid_i = 4'hF;
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.cfg_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.cfg_ready_o); else n_pass++;
        n_checks++; if (bus.cfg_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.cfg_err_o); else n_pass++;
        n_checks++; if (bus.flush_req_o !== 1'b0) $display("FAIL rst_flush: got %b want 0", bus.flush_req_o); else n_pass++;
        n_checks++; if (bus.dynamic_offset_o !== 5'(DEF)) $display("FAIL rst_offset: got %0d want %0d", bus.dynamic_offset_o, DEF); else n_pass++;
        n_checks++; if (bus.core_req_valid_o !== 4'hF) $display("FAIL rst_gate: got %h want f", bus.core_req_valid_o); else n_pass++;
        rst_ni = 1'b1;
        tick();
        $display("reset: released, offset=%0d", bus.dynamic_offset_o);
    endtask

    task automatic test_switch_idle();
        bit e_busy [5] = '{0, 1, 1, 0, 0};
        int e_off  [5] = '{6, 6, 6, 7, 7};
        set_idle();
        bus.core_req_valid_i = 4'hF;
        for (int c = 0; c < 5; c++) begin
            bus.cfg_valid_i  = (c == 0);
            bus.cfg_offset_i = 5'd7;
            #1;
            n_checks++; if (bus.busy_o !== e_busy[c]) $display("FAIL sw_busy c%0d: got %b want %b", c, bus.busy_o, e_busy[c]); else n_pass++;
            n_checks++; if (bus.cfg_ready_o !== !e_busy[c]) $display("FAIL sw_ready c%0d: got %b want %b", c, bus.cfg_ready_o, !e_busy[c]); else n_pass++;
            n_checks++; if (bus.dynamic_offset_o !== 5'(e_off[c])) $display("FAIL sw_offset c%0d: got %0d want %0d", c, bus.dynamic_offset_o, e_off[c]); else n_pass++;
            n_checks++; if (bus.core_req_valid_o !== (e_busy[c] ? 4'h0 : 4'hF)) $display("FAIL sw_gate c%0d: got %h want %h", c, bus.core_req_valid_o, e_busy[c] ? 4'h0 : 4'hF); else n_pass++;
            tick();
        end
        $display("switch_idle: offset now %0d", bus.dynamic_offset_o);
    endtask

    task automatic test_drain();
        set_idle();
        bus.core_req_valid_i = 4'b0001;
        bus.core_req_ready_i = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus.core_req_valid_o[0] !== 1'b1) $display("FAIL drain_issue k%0d: got %b want 1", k, bus.core_req_valid_o[0]); else n_pass++;
            tick();
        end
        set_idle();
        bus.cfg_valid_i  = 1'b1;
        bus.cfg_offset_i = 5'd8;
        #1;
        n_checks++; if (bus.cfg_ready_o !== 1'b1) $display("FAIL drain_accept: got %b want 1", bus.cfg_ready_o); else n_pass++;
        tick();
        for (int c = 1; c <= 12; c++) begin
            bus.cfg_valid_i      = 1'b0;
            bus.core_req_valid_i = 4'hF;
            bus.core_req_ready_i = 4'h0;
            bus.core_rsp_ready_i = 4'b0001;
            bus.core_rsp_valid_i = (c == 4 || c == 6 || c == 9) ? 4'b0001 : 4'b0000;
            #1;
            n_checks++; if (bus.busy_o !== (c <= 10)) $display("FAIL drain_busy c%0d: got %b want %b", c, bus.busy_o, c <= 10); else n_pass++;
            n_checks++; if (bus.core_req_valid_o !== ((c <= 10) ? 4'h0 : 4'hF)) $display("FAIL drain_gate c%0d: got %h want %h", c, bus.core_req_valid_o, (c <= 10) ? 4'h0 : 4'hF); else n_pass++;
            n_checks++; if (bus.dynamic_offset_o !== ((c >= 11) ? 5'd8 : 5'd7)) $display("FAIL drain_offset c%0d: got %0d want %0d", c, bus.dynamic_offset_o, (c >= 11) ? 8 : 7); else n_pass++;
            tick();
        end
        $display("drain: offset now %0d", bus.dynamic_offset_o);
    endtask

    task automatic test_cfg_boundaries();
        int e_off;
        // offset 31 is illegal: 31 + 2 > 32
        set_idle();
        bus.core_req_valid_i = 4'hF;
        bus.cfg_valid_i = 1'b1; bus.cfg_offset_i = 5'd31;
        #1;
        n_checks++; if (bus.cfg_ready_o !== 1'b1) $display("FAIL ill_ready: got %b want 1", bus.cfg_ready_o); else n_pass++;
        tick();
        bus.cfg_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.cfg_err_o !== 1'b1) $display("FAIL ill_err: got %b want 1", bus.cfg_err_o); else n_pass++;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL ill_busy: got %b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.core_req_valid_o !== 4'hF) $display("FAIL ill_gate: got %h want f", bus.core_req_valid_o); else n_pass++;
        n_checks++; if (bus.dynamic_offset_o !== 5'd8) $display("FAIL ill_offset: got %0d want 8", bus.dynamic_offset_o); else n_pass++;
        tick();
        #1;
        n_checks++; if (bus.cfg_err_o !== 1'b0) $display("FAIL ill_err_once: got %b want 0", bus.cfg_err_o); else n_pass++;
        // same offset: consumed silently
        bus.cfg_valid_i = 1'b1; bus.cfg_offset_i = 5'd8;
        tick();
        bus.cfg_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL same_busy: got %b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.cfg_err_o !== 1'b0) $display("FAIL same_err: got %b want 0", bus.cfg_err_o); else n_pass++;
        tick();
        // offset 30 is the largest legal value: 30 + 2 == 32
        bus.cfg_valid_i = 1'b1; bus.cfg_offset_i = 5'd30;
        tick();
        bus.cfg_valid_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            e_off = (c == 3) ? 30 : 8;
            n_checks++; if (bus.busy_o !== (c < 3)) $display("FAIL edge_busy c%0d: got %b want %b", c, bus.busy_o, c < 3); else n_pass++;
            n_checks++; if (bus.cfg_err_o !== 1'b0) $display("FAIL edge_err c%0d: got %b want 0", c, bus.cfg_err_o); else n_pass++;
            n_checks++; if (bus.dynamic_offset_o !== 5'(e_off)) $display("FAIL edge_offset c%0d: got %0d want %0d", c, bus.dynamic_offset_o, e_off); else n_pass++;
            tick();
        end
        $display("cfg_boundaries: offset now %0d", bus.dynamic_offset_o);
    endtask

    task automatic test_overflow();
        set_idle();
        bus.core_req_valid_i = 4'b0010;
        bus.core_req_ready_i = 4'b0010;
        for (int k = 0; k < MAXO; k++) begin
            #1;
            n_checks++; if (bus.core_req_valid_o[1] !== 1'b1) $display("FAIL ovf_open k%0d: got %b want 1", k, bus.core_req_valid_o[1]); else n_pass++;
            tick();
        end
        // count is 8: gated; one response brings it to 7
        bus.core_rsp_valid_i = 4'b0010; bus.core_rsp_ready_i = 4'b0010;
        #1;
        n_checks++; if (bus.core_req_valid_o[1] !== 1'b0) $display("FAIL ovf_gate: got %b want 0", bus.core_req_valid_o[1]); else n_pass++;
        tick();
        // count 7: request and response together keep it at 7
        #1;
        n_checks++; if (bus.core_req_valid_o[1] !== 1'b1) $display("FAIL ovf_reopen: got %b want 1", bus.core_req_valid_o[1]); else n_pass++;
        tick();
        bus.core_rsp_valid_i = 4'b0000;
        #1;
        n_checks++; if (bus.core_req_valid_o[1] !== 1'b1) $display("FAIL ovf_simul: got %b want 1", bus.core_req_valid_o[1]); else n_pass++;
        tick();
        #1;
        n_checks++; if (bus.core_req_valid_o[1] !== 1'b0) $display("FAIL ovf_regate: got %b want 0", bus.core_req_valid_o[1]); else n_pass++;
        bus.core_req_valid_i = 4'b0000;
        bus.core_rsp_valid_i = 4'b0010;
        for (int k = 0; k < MAXO; k++) tick();
        set_idle();
        $display("overflow: core1 count per model = %0d", m_cnt[1]);
    endtask

`ifdef TCDM_CACHE_OFFSET_FLUSH_EN
    task automatic test_flush();
        int old_off;
        old_off = m_offset;
        set_idle();
        bus.cfg_valid_i = 1'b1; bus.cfg_offset_i = 5'd9;
        tick();
        bus.cfg_valid_i = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            bus.flush_done_i = (c == 22);
            #1;
            n_checks++; if (bus.flush_req_o !== (c >= 2 && c <= 22)) $display("FAIL fl_req c%0d: got %b want %b", c, bus.flush_req_o, c >= 2 && c <= 22); else n_pass++;
            n_checks++; if (bus.dynamic_offset_o !== ((c == 24) ? 5'd9 : 5'(old_off))) $display("FAIL fl_offset c%0d: got %0d want %0d", c, bus.dynamic_offset_o, (c == 24) ? 9 : old_off); else n_pass++;
            n_checks++; if (bus.busy_o !== (c <= 23)) $display("FAIL fl_busy c%0d: got %b want %b", c, bus.busy_o, c <= 23); else n_pass++;
            tick();
        end
        $display("flush: offset now %0d", bus.dynamic_offset_o);
    endtask
`endif

    task automatic test_reset_mid();
        set_idle();
        bus.core_req_valid_i = 4'b0100;
        bus.core_req_ready_i = 4'b0100;
        tick(); tick();
        set_idle();
        bus.cfg_valid_i = 1'b1; bus.cfg_offset_i = 5'd12;
        tick();
        bus.cfg_valid_i = 1'b0;
        bus.core_req_valid_i = 4'hF;
        #1;
        n_checks++; if (bus.busy_o !== 1'b1) $display("FAIL mid_drain: got %b want 1", bus.busy_o); else n_pass++;
        tick();
        #3 rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy_o); else n_pass++;
        n_checks++; if (bus.cfg_ready_o !== 1'b1) $display("FAIL mid_ready: got %b want 1", bus.cfg_ready_o); else n_pass++;
        n_checks++; if (bus.dynamic_offset_o !== 5'(DEF)) $display("FAIL mid_offset: got %0d want %0d", bus.dynamic_offset_o, DEF); else n_pass++;
        n_checks++; if (bus.core_req_valid_o !== 4'hF) $display("FAIL mid_gate: got %h want f", bus.core_req_valid_o); else n_pass++;
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        // counters were cleared, so a new change completes without responses
        bus.cfg_valid_i = 1'b1; bus.cfg_offset_i = 5'd11;
        tick();
        bus.cfg_valid_i = 1'b0;
        tick(); tick();
        #1;
        n_checks++; if (bus.dynamic_offset_o !== 5'd11) $display("FAIL mid_after: got %0d want 11", bus.dynamic_offset_o); else n_pass++;
        n_checks++; if (bus.core_req_valid_o !== 4'hF) $display("FAIL mid_release: got %h want f", bus.core_req_valid_o); else n_pass++;
        tick();
        $display("reset_mid: offset now %0d", bus.dynamic_offset_o);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_checks - n_pass;
        set_idle();
        for (int c = 0; c < 600; c++) begin
            bit accepted;
            bus.core_req_valid_i = 4'($urandom);
            bus.core_req_ready_i = 4'($urandom);
            bus.core_rsp_ready_i = 4'($urandom);
            for (int i = 0; i < NC; i++)
                bus.core_rsp_valid_i[i] = ($urandom_range(0, 1) == 1) && (m_cnt[i] > 0);
            bus.flush_done_i = ($urandom_range(0, 3) == 0);
            if (!bus.cfg_valid_i && $urandom_range(0, 15) == 0) begin
                bus.cfg_valid_i  = 1'b1;
                bus.cfg_offset_i = 5'($urandom_range(0, 31));
            end
            #1;
            n_checks++; if (bus.core_req_valid_o !== exp_req_o()) $display("FAIL rnd_gate c%0d: got %h want %h", c, bus.core_req_valid_o, exp_req_o()); else n_pass++;
            n_checks++; if (bus.busy_o !== m_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, bus.busy_o, m_busy); else n_pass++;
            n_checks++; if (bus.cfg_ready_o !== !m_busy) $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.cfg_ready_o, !m_busy); else n_pass++;
            n_checks++; if (bus.cfg_err_o !== m_err) $display("FAIL rnd_err c%0d: got %b want %b", c, bus.cfg_err_o, m_err); else n_pass++;
            n_checks++; if (bus.dynamic_offset_o !== 5'(m_offset)) $display("FAIL rnd_offset c%0d: got %0d want %0d", c, bus.dynamic_offset_o, m_offset); else n_pass++;
            n_checks++; if (bus.flush_req_o !== exp_flush()) $display("FAIL rnd_flush c%0d: got %b want %b", c, bus.flush_req_o, exp_flush()); else n_pass++;
            accepted = bus.cfg_valid_i && !m_busy;
            tick();
            if (accepted) bus.cfg_valid_i = 1'b0;
        end
        set_idle();
        $display("random: 600 cycles, %0d new failures", (n_checks - n_pass) - errs_before);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_switch_idle();
        test_drain();
        test_cfg_boundaries();
        test_overflow();
`ifdef TCDM_CACHE_OFFSET_FLUSH_EN
        test_flush();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
